uart_rx_ovs: RTL and testbench
==============================

UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 Parameter WORD_LENGTH, default 8, number of data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16, clk ticks per bit (16 x 9615 baud from the 153.846 kHz clock).
REQ-003 clk  input  1  receiver clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 SerialDataIn  input  1  asynchronous serial line; idles high.
REQ-006 Clear_RX_Flag  input  1  synchronous clear of RX_FLAG and all error flags.
REQ-007 DATARX  output  WORD_LENGTH  last received word.
REQ-008 RX_FLAG  output  1  received word available.
REQ-009 ParityError  output  1  parity mismatch on last frame.
REQ-010 FramingError  output  1  stop bit sampled low on last frame.
REQ-011 Overrun  output  1  a frame completed while RX_FLAG was already set.

Function
REQ-012 SerialDataIn SHALL pass through a 2-flop synchronizer; both flops reset to 1.
REQ-013 Each bit SHALL be decided by 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of the bit.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-015 IDLE -> START on the first synchronized low; the tick counter restarts at 0.
REQ-016 START: a majority value of 1 at mid-bit SHALL be treated as a glitch, return to IDLE and set no flags.
REQ-017 DATA SHALL capture WORD_LENGTH bits LSB first, one bit per OVERSAMPLE ticks, into a shift register.
REQ-018 PARITY (macro only) SHALL compare the sampled bit with even parity (XOR) of the data bits.
REQ-019 STOP: at mid-bit, DATARX SHALL load the shift register and RX_FLAG SHALL assert exactly 1 clk later.
REQ-020 A stop bit sampled low SHALL set FramingError, still deliver DATARX and RX_FLAG, and go to WAIT_HIGH.
REQ-021 A valid stop bit SHALL return the FSM to IDLE at mid-stop, so back-to-back frames are accepted.
REQ-022 WAIT_HIGH -> IDLE on the first synchronized high.
REQ-023 A frame completing while RX_FLAG=1 SHALL overwrite DATARX and set Overrun.
REQ-024 Error flags are sticky until Clear_RX_Flag.
REQ-025 Clear_RX_Flag=1 clears RX_FLAG, ParityError, FramingError and Overrun on the next edge.
REQ-026 Set and clear in the same cycle: set SHALL win.
REQ-027 The tick counter SHALL be $clog2(OVERSAMPLE) bits wide and wrap to 0 at OVERSAMPLE-1.

Reset
REQ-028 Reset low SHALL immediately force state IDLE; counters, shift register and DATARX to 0; all flags to 0.
REQ-029 A reset mid-frame SHALL abandon the frame with no flag set; reception restarts on the next falling edge after release.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: a parity bit is expected between the data bits and the stop bit, and ParityError is driven per REQ-018.
REQ-031 Macro undefined: the PARITY state is skipped, DATA -> STOP directly, and ParityError is tied 0.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum and the OVERSAMPLE and WORD_LENGTH defaults, shared with the transmitter.
REQ-033 Sub-module uart_rx_sync SHALL hold the synchronizer and the 3-sample majority voter.

Verification
REQ-034 Frame 0x55 (parity 0, stop 1) at 16 ticks/bit -> DATARX=0x55, RX_FLAG=1 one clk after mid-stop, no error flags.
REQ-035 Frame 0xA3 with parity bit 1 (macro on) -> DATARX=0xA3, ParityError=1; Clear_RX_Flag pulse -> all flags 0.
REQ-036 Line low for 4 ticks then high -> FSM back in IDLE, RX_FLAG stays 0.
REQ-037 Frame 0x0F with stop bit 0, line held low 40 ticks -> FramingError=1, DATARX=0x0F, no new frame until the line goes high.
REQ-038 Frames 0x12 then 0x34 back-to-back, no clear -> DATARX=0x34, Overrun=1.
REQ-039 Reset asserted during DATA bit 3 -> all outputs 0 at once; next frame 0xC4 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry, the receiver FSM encoding
// and the majority-vote helper used by the oversampling front end.
package uart_pkg;

  localparam int OVERSAMPLE_DEF  = 16;
  localparam int WORD_LENGTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Line front end: two-flop synchronizer (idles high) plus a 2-of-3 majority
// over the current and two previous synchronized samples.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic serial_in,
  output logic rx_s,
  output logic rx_maj
);

  logic       meta;
  logic [1:0] hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      hist <= 2'b11;
    end else begin
      meta <= serial_in;
      rx_s <= meta;
      hist <= {hist[0], rx_s};
    end
  end

  // Evaluated at tick OVERSAMPLE/2+1, this covers ticks /2-1, /2 and /2+1.
  assign rx_maj = maj3(hist[1], hist[0], rx_s);

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver. Define UART_RX_PARITY_EN to expect an even
// parity bit between the data bits and the stop bit.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   SerialDataIn,
  input  logic                   Clear_RX_Flag,
  output logic [WORD_LENGTH-1:0] DATARX,
  output logic                   RX_FLAG,
  output logic                   ParityError,
  output logic                   FramingError,
  output logic                   Overrun,
  output rx_state_e              dbg_state
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WORD_LENGTH + 1);

  // Handshake: RX_FLAG is "word valid" and stays high until the consumer
  // pulses Clear_RX_Flag; a new word arriving first overwrites and sets Overrun.

  rx_state_e              state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_cnt;
  logic [WORD_LENGTH-1:0] shift_q;
  logic                   rx_s, rx_maj;
  logic                   mid, wrap;
  logic                   cnt_clr, shift_en, load_word, stop_bad;
  logic                   done_d, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_cap, par_bad;
`endif

  uart_rx_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .serial_in (SerialDataIn),
    .rx_s      (rx_s),
    .rx_maj    (rx_maj)
  );

  assign mid       = (cnt == CW'(OVERSAMPLE / 2 + 1));
  assign wrap      = (cnt == CW'(OVERSAMPLE - 1));
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    load_word = 1'b0;
    stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_cap   = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (mid && rx_maj) begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end else if (wrap) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        shift_en = mid;
        if (wrap && bit_cnt == BW'(WORD_LENGTH))
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        par_cap = mid;
        if (wrap) state_nxt = STOP;
      end
`endif
      STOP: begin
        // Leave at mid-stop so a following start edge is never missed.
        if (mid) begin
          load_word = 1'b1;
          cnt_clr   = 1'b1;
          if (rx_maj) begin
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_clr = 1'b1;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      DATARX       <= '0;
      done_d       <= 1'b0;
      ferr_d       <= 1'b0;
      RX_FLAG      <= 1'b0;
      FramingError <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= (cnt_clr || wrap) ? '0 : cnt + CW'(1);
      if (state != DATA)  bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + BW'(1);
      if (shift_en)  shift_q <= {rx_maj, shift_q[WORD_LENGTH-1:1]};
      if (load_word) DATARX  <= shift_q;
      // Flags follow the word by one clock; a set beats a same-cycle clear.
      done_d       <= load_word;
      ferr_d       <= stop_bad;
      RX_FLAG      <= done_d | (RX_FLAG & ~Clear_RX_Flag);
      FramingError <= (done_d & ferr_d) | (FramingError & ~Clear_RX_Flag);
      Overrun      <= (done_d & RX_FLAG) | (Overrun & ~Clear_RX_Flag);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bad     <= 1'b0;
      ParityError <= 1'b0;
    end else begin
      if (par_cap) par_bad <= rx_maj ^ (^shift_q);
      ParityError <= (done_d & par_bad) | (ParityError & ~Clear_RX_Flag);
    end
  end
`else
  assign ParityError = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Self-checking bench for uart_rx_ovs: frames are queued when driven and
// checked (data, flag timing) when the receiver raises RX_FLAG or Overrun.
module tb_uart_rx_ovs;
  import uart_pkg::*;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int OVS = 16;
  // Line fall to RX_FLAG: 2 sync + 1 idle + (start + data [+ parity]) bits + mid-stop + 2.
  localparam int LAT = PAR_EN ? 174 : 158;

  logic      clk = 1'b0;
  logic      reset;
  logic      SerialDataIn;
  logic      Clear_RX_Flag;
  logic [7:0] DATARX;
  logic      RX_FLAG, ParityError, FramingError, Overrun;
  rx_state_e dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  int         t0_q[$];
  logic [7:0] mon_exp;
  int         mon_t0;
  logic       flag_q = 1'b0, ovr_q = 1'b0;
  logic [7:0] datarx_q = '0;

  uart_rx_ovs #(.WORD_LENGTH(8), .OVERSAMPLE(OVS)) dut (
    .clk           (clk),
    .reset         (reset),
    .SerialDataIn  (SerialDataIn),
    .Clear_RX_Flag (Clear_RX_Flag),
    .DATARX        (DATARX),
    .RX_FLAG       (RX_FLAG),
    .ParityError   (ParityError),
    .FramingError  (FramingError),
    .Overrun       (Overrun),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // driver tasks (called on a falling clock edge)
  task automatic drive_bit(input logic b);
    SerialDataIn = b;
    repeat (OVS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip,
                            input logic stop_bit, input bit push);
    logic [10:0] bits;
    bits = {stop_bit, (^d) ^ par_flip, d, 1'b0};
    if (push) begin
      exp_q.push_back(d);
      t0_q.push_back(cyc);
    end
    for (int i = 0; i < 11; i++) begin
      if (i == 9 && !PAR_EN) continue;
      drive_bit(bits[i]);
    end
  endtask

  task automatic pulse_clear();
    Clear_RX_Flag = 1'b1;
    @(negedge clk);
    Clear_RX_Flag = 1'b0;
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic idle(input int n);
    SerialDataIn = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // scoreboard: a completed frame shows up as RX_FLAG or Overrun rising
  always @(negedge clk) begin
    if (reset && ((RX_FLAG && !flag_q) || (Overrun && !ovr_q))) begin
      check("frame_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        mon_t0  = t0_q.pop_front();
        check("datarx", DATARX, mon_exp);
        check("datarx_before_flag", datarx_q, mon_exp);
        check("flag_latency", cyc - mon_t0, LAT);
      end
    end
    flag_q   = RX_FLAG;
    ovr_q    = Overrun;
    datarx_q = DATARX;
  end

  task automatic check_flags(input string tag, input logic rx, input logic pe,
                             input logic fe, input logic ov);
    check({tag, "_rx_flag"}, RX_FLAG, rx);
    check({tag, "_parity"},  ParityError, pe);
    check({tag, "_framing"}, FramingError, fe);
    check({tag, "_overrun"}, Overrun, ov);
  endtask

  initial begin
    reset         = 1'b0;
    SerialDataIn  = 1'b1;
    Clear_RX_Flag = 1'b0;
    #12;
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_datarx", DATARX, 8'h00);
    check("reset_state", dbg_state, IDLE);
    @(negedge clk);
    reset = 1'b1;
    idle(4);
    check("post_reset_state", dbg_state, IDLE);

    // clean frame
    send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    wait_drained(400);
    check_flags("f55", 1'b1, 1'b0, 1'b0, 1'b0);
    check("f55_state", dbg_state, IDLE);
    pulse_clear();
    check("f55_cleared", RX_FLAG, 1'b0);
    idle(5);

    // wrong parity bit
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
    wait_drained(400);
    check_flags("fa3", 1'b1, PAR_EN, 1'b0, 1'b0);
    pulse_clear();
    check_flags("fa3_clr", 1'b0, 1'b0, 1'b0, 1'b0);
    idle(5);

    // start-bit glitch
    SerialDataIn = 1'b0;
    repeat (4) @(negedge clk);
    SerialDataIn = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_in_start", dbg_state, START);
    idle(20);
    check("glitch_idle", dbg_state, IDLE);
    check("glitch_no_flag", RX_FLAG, 1'b0);

    // stop bit low, line held low 40 ticks in total
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
    SerialDataIn = 1'b0;
    repeat (40 - OVS) @(negedge clk);
    check("frm_wait_high", dbg_state, WAIT_HIGH);
    check("frm_datarx", DATARX, 8'h0F);
    check_flags("frm", 1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("frm_back_idle", dbg_state, IDLE);
    wait_drained(10);
    pulse_clear();
    check_flags("frm_clr", 1'b0, 1'b0, 1'b0, 1'b0);
    idle(5);

    // clear held high while a frame completes: the set wins for one cycle
    Clear_RX_Flag = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    wait_drained(400);
    @(negedge clk);
    check("setwin_cleared_after", RX_FLAG, 1'b0);
    Clear_RX_Flag = 1'b0;
    idle(5);

    // back-to-back frames without clearing
    send_frame(8'h12, 1'b0, 1'b1, 1'b1);
    send_frame(8'h34, 1'b0, 1'b1, 1'b1);
    wait_drained(400);
    check("b2b_datarx", DATARX, 8'h34);
    check_flags("b2b", 1'b1, 1'b0, 1'b0, 1'b1);
    idle(5);

    // reset during data bit 3, flags and DATARX still set from above
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    SerialDataIn = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_mid_in_data", dbg_state, DATA);
    #2 reset = 1'b0;
    #1;
    check_flags("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mid_datarx", DATARX, 8'h00);
    check("rst_mid_state", dbg_state, IDLE);
    SerialDataIn = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(5);
    send_frame(8'hC4, 1'b0, 1'b1, 1'b1);
    wait_drained(400);
    check_flags("fc4", 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
